// File: rtl/seg_display_arbiter_if.sv
// Display-sharing bus between the per-mode display sources and the arbiter.
// Sources supply requests and frame contents; the arbiter returns grant status and the scanned pins.
interface seg_display_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   localparam int unsigned OW = $clog2(NREQ);

   logic [NREQ-1:0]    req;
   logic [NREQ*64-1:0] frame;
   logic [NREQ*8-1:0]  digit_en;
   logic [NREQ-1:0]    grant;
   logic [OW-1:0]      owner;
   logic               busy;
   logic [7:0]         AN;
   logic [7:0]         HEX;

   modport master (
      output req, frame, digit_en,
      input  grant, owner, busy, AN, HEX
   );

   modport slave (
      input  req, frame, digit_en,
      output grant, owner, busy, AN, HEX
   );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 8-digit seven-segment display, with a minimum hold time,
// a blanking gap on every hand-over, and the digit scan for the current owner.
module seg_display_arbiter #(
   parameter int unsigned NREQ         = 4,
   parameter int unsigned HOLD_TICKS   = 20000,
   parameter int unsigned BLANK_CYCLES = 100,
   parameter int unsigned SCAN_DIV     = 1
) (
   input logic                 clock,
   input logic                 rst,
   seg_display_arbiter_if.slave bus
);
   localparam int unsigned OW = $clog2(NREQ);
   localparam int unsigned HW = (HOLD_TICKS   > 1) ? $clog2(HOLD_TICKS)   : 1;
   localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int unsigned PW = (SCAN_DIV     > 1) ? $clog2(SCAN_DIV)     : 1;

   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [OW-1:0] OWNER_RST  = OW'(NREQ - 1);

   typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_t;

   state_t         state, state_nxt;
   logic [NREQ-1:0] grant, grant_nxt;
   logic [OW-1:0]  owner, owner_nxt;
   logic           busy, busy_nxt;
   logic [HW-1:0]  hold_cnt, hold_nxt;
   logic [BW-1:0]  blank_cnt, blank_nxt;
   logic [7:0]     an_q, an_nxt;
   logic [7:0]     hex_q, hex_nxt;
   logic [PW-1:0]  presc;
   logic [2:0]     sel;

   logic [NREQ-1:0] above, req_hi, owner_oh;
   logic [OW-1:0]   win, win_lo, win_hi;
   logic            any_req, other_req;

   // Free-running digit scan, independent of arbitration state
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         presc <= '0;
         sel   <= '0;
      end else if (presc == PRESC_LAST) begin
         presc <= '0;
         sel   <= sel + 3'd1;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Round-robin pick: lowest requester above the owner, else lowest overall (owner itself last)
   always_comb begin
      above  = '0;
      win_lo = '0;
      win_hi = '0;
      for (int i = 0; i < int'(NREQ); i++) above[OW'(i)] = (OW'(i) > owner);
      req_hi = bus.req & above;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (bus.req[OW'(i)]) win_lo = OW'(i);
         if (req_hi[OW'(i)])  win_hi = OW'(i);
      end
      win       = (req_hi != '0) ? win_hi : win_lo;
      any_req   = (bus.req != '0);
      owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner;
      other_req = ((bus.req & ~owner_oh) != '0);
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      owner_nxt = owner;
      hold_nxt  = hold_cnt;
      blank_nxt = blank_cnt;
      an_nxt    = 8'hFF;
      hex_nxt   = 8'hFF;

      case (state)
         IDLE: begin
            grant_nxt = '0;
            if (any_req) begin
               owner_nxt = win;
               grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << win;
               hold_nxt  = '0;
               state_nxt = OWN;
            end
         end
         OWN: begin
            if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + HW'(1);
            // A drop wins over a simultaneous hold expiry; both lead to the same blanking gap
            if (!bus.req[owner] || (other_req && hold_cnt == HOLD_LAST)) begin
               state_nxt = SWITCH;
               grant_nxt = '0;
               blank_nxt = '0;
            end
            an_nxt  = ~(8'h01 << sel) | ~bus.digit_en[{owner, 3'b000} +: 8];
            hex_nxt = bus.frame[{owner, sel, 3'b000} +: 8];
         end
         SWITCH: begin
            grant_nxt = '0;
            if (blank_cnt == BLANK_LAST) begin
               if (any_req) begin
                  owner_nxt = win;
                  grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << win;
                  hold_nxt  = '0;
                  state_nxt = OWN;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               blank_nxt = blank_cnt + BW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         grant     <= '0;
         owner     <= OWNER_RST;
         busy      <= 1'b0;
         hold_cnt  <= '0;
         blank_cnt <= '0;
         an_q      <= 8'hFF;
         hex_q     <= 8'hFF;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         owner     <= owner_nxt;
         busy      <= busy_nxt;
         hold_cnt  <= hold_nxt;
         blank_cnt <= blank_nxt;
         an_q      <= an_nxt;
         hex_q     <= hex_nxt;
      end
   end

   assign bus.grant = grant;
   assign bus.owner = owner;
   assign bus.busy  = busy;
   assign bus.AN    = an_q;
   assign bus.HEX   = hex_q;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: grant sequencing, blanking gaps, scan output and reset.
module tb_seg_display_arbiter;
   logic clock = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   ncyc;

   logic [7:0] an_ff [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   logic [7:0] an_fc [8] = '{8'hFF, 8'hFF, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

   seg_display_arbiter_if #(.NREQ(4)) bus  ();
   seg_display_arbiter_if #(.NREQ(4)) bus4 ();

   seg_display_arbiter #(.NREQ(4), .HOLD_TICKS(16), .BLANK_CYCLES(2), .SCAN_DIV(1)) dut (
      .clock(clock), .rst(rst), .bus(bus)
   );
   seg_display_arbiter #(.NREQ(4), .HOLD_TICKS(16), .BLANK_CYCLES(2), .SCAN_DIV(4)) dut4 (
      .clock(clock), .rst(rst), .bus(bus4)
   );

   always #5 clock = ~clock;

   // Edges seen since reset release; the scan position before edge n is (n-1)
   always @(posedge clock or negedge rst) begin
      if (!rst) ncyc <= 0;
      else      ncyc <= ncyc + 1;
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [7:0] eg;
      int d;

      rst = 1'b0;
      bus.req = 4'b0000;
      bus4.req = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 8; k++) begin
            bus.frame[i*64 + k*8 +: 8]  = {4'(i + 1), 4'(k)};
            bus4.frame[i*64 + k*8 +: 8] = {4'(i + 1), 4'(k)};
         end
         bus.digit_en[i*8 +: 8]  = (i == 2) ? 8'hFC : 8'hFF;
         bus4.digit_en[i*8 +: 8] = 8'hFF;
      end

      // Reset state
      repeat (3) tick();
      check("rst_grant", 8'(bus.grant), 8'h00);
      check("rst_owner", 8'(bus.owner), 8'h03);
      check("rst_busy",  8'(bus.busy),  8'h00);
      check("rst_an",    bus.AN,        8'hFF);
      check("rst_hex",   bus.HEX,       8'hFF);

      // Single requester from IDLE, then scan with digits 0,1 disabled
      rst = 1'b1;
      bus.req = 4'b0100;
      tick();
      check("t1_grant", 8'(bus.grant), 8'h04);
      check("t1_owner", 8'(bus.owner), 8'h02);
      check("t1_busy",  8'(bus.busy),  8'h01);
      check("t1_an_dark", bus.AN,      8'hFF);
      for (int k = 2; k <= 17; k++) begin
         tick();
         d = (ncyc - 1) % 8;
         check($sformatf("t1_an_%0d", k),  bus.AN,  an_fc[d]);
         check($sformatf("t1_hex_%0d", k), bus.HEX, 8'h30 | 8'(d));
      end
      bus.req = 4'b0000;
      tick();
      check("t1_drop_grant", 8'(bus.grant), 8'h00);
      check("t1_drop_busy",  8'(bus.busy),  8'h01);
      tick();
      tick();
      check("t1_idle_busy",  8'(bus.busy),  8'h00);
      check("t1_idle_grant", 8'(bus.grant), 8'h00);

      // Two competitors: 16-cycle holds separated by 2-cycle gaps
      bus.req = 4'b0011;
      for (int i = 1; i <= 37; i++) begin
         tick();
         if (i <= 16 || i == 37)     eg = 8'h01;
         else if (i >= 19 && i <= 34) eg = 8'h02;
         else                         eg = 8'h00;
         check($sformatf("t2_grant_%0d", i), 8'(bus.grant), eg);
         if (i == 18 || i == 19) begin
            check($sformatf("t2_an_blank_%0d", i),  bus.AN,  8'hFF);
            check($sformatf("t2_hex_blank_%0d", i), bus.HEX, 8'hFF);
         end
         if (i == 19) check("t2_owner1", 8'(bus.owner), 8'h01);
      end

      // Lone owner 1 keeps the grant indefinitely
      bus.req = 4'b0010;
      tick();
      check("t3_gap_a", 8'(bus.grant), 8'h00);
      tick();
      check("t3_gap_b", 8'(bus.grant), 8'h00);
      tick();
      check("t3_grant", 8'(bus.grant), 8'h02);
      for (int j = 0; j < 1000; j++) begin
         tick();
         check($sformatf("t3_hold_%0d", j), 8'(bus.grant), 8'h02);
         if (j < 16) begin
            d = (ncyc - 1) % 8;
            check($sformatf("t3_an_%0d", j),  bus.AN,  an_ff[d]);
            check($sformatf("t3_hex_%0d", j), bus.HEX, 8'h20 | 8'(d));
         end
      end

      // Owner 0 drops early with req[3] waiting: hand-over without a hold wait
      bus.req = 4'b0001;
      repeat (3) tick();
      check("t4_grant0", 8'(bus.grant), 8'h01);
      check("t4_owner0", 8'(bus.owner), 8'h00);
      repeat (4) tick();
      check("t4_hold0", 8'(bus.grant), 8'h01);
      bus.req = 4'b1000;
      tick();
      check("t4_gap_a", 8'(bus.grant), 8'h00);
      tick();
      check("t4_gap_b", 8'(bus.grant), 8'h00);
      tick();
      check("t4_grant3", 8'(bus.grant), 8'h08);
      check("t4_owner3", 8'(bus.owner), 8'h03);
      // Request withdrawn during blanking: the pick finds nothing and goes idle
      bus.req = 4'b0010;
      tick();
      bus.req = 4'b0000;
      tick();
      tick();
      check("t4_idle_busy",  8'(bus.busy),  8'h00);
      check("t4_idle_grant", 8'(bus.grant), 8'h00);
      check("t4_idle_owner", 8'(bus.owner), 8'h03);

      // Asynchronous reset in the middle of ownership
      bus.req = 4'b0100;
      tick();
      check("t5_pre_grant", 8'(bus.grant), 8'h04);
      repeat (3) tick();
      #2 rst = 1'b0;
      #1;
      check("t5_rst_grant", 8'(bus.grant), 8'h00);
      check("t5_rst_an",    bus.AN,        8'hFF);
      check("t5_rst_hex",   bus.HEX,       8'hFF);
      check("t5_rst_owner", 8'(bus.owner), 8'h03);
      check("t5_rst_busy",  8'(bus.busy),  8'h00);
      check("t5_rst_grant4", 8'(bus4.grant), 8'h00);
      bus.req = 4'b1001;
      @(posedge clock);
      #1 rst = 1'b1;
      tick();
      check("t5_grant", 8'(bus.grant), 8'h01);
      check("t5_owner", 8'(bus.owner), 8'h00);
      check("t6_grant4", 8'(bus4.grant), 8'h01);
      check("t6_an_dark", bus4.AN, 8'hFF);

      // Divided scan: each digit held four cycles, full scan over 32 cycles
      for (int n = 2; n <= 33; n++) begin
         tick();
         d = ((ncyc - 1) / 4) % 8;
         check($sformatf("t6_an_%0d", n),  bus4.AN,  an_ff[d]);
         check($sformatf("t6_hex_%0d", n), bus4.HEX, 8'h10 | 8'(d));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
